// File: rtl/jtframe_mr_upload.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jtframe_mr_upload                                                          |
// | Upload responder for the MiSTer HPS ioctl channel. Each ioctl_rd during an |
// | upload on index INDEX fetches one byte (or two, WIDE=1) from the game save |
// | memory through a req/ok handshake and presents it on ioctl_din.            |
// |                                                                            |
// | Ports                                                                      |
// |   clk_rom, rst            clock, asynchronous active-high reset            |
// |   ioctl_upload/index/rd/addr   HPS request side                           |
// |   ioctl_din               response data, 8 bits (WIDE=0) or 16 (WIDE=1)   |
// |   mem_sel/addr/req/dout/ok    save memory read port                       |
// |   busy, done, err         fetch in progress, session end pulse, sticky err |
// |                                                                            |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module jtframe_mr_upload #(
  parameter int         WIDE  = 0,
  parameter int         AW    = 10,
  parameter int         SIZE  = 1024,
  parameter logic [7:0] INDEX = 8'd2,
  parameter int         TOUT  = 64
) (
  input  logic                          clk_rom,
  input  logic                          rst,
  input  logic                          ioctl_upload,
  input  logic [7:0]                    ioctl_index,
  input  logic                          ioctl_rd,
  input  logic [26:0]                   ioctl_addr,
  output logic [(WIDE != 0 ? 16:8)-1:0] ioctl_din,
  output logic                          mem_sel,
  output logic [AW-1:0]                 mem_addr,
  output logic                          mem_req,
  input  logic [7:0]                    mem_dout,
  input  logic                          mem_ok,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int          DW   = (WIDE != 0) ? 16 : 8;
  localparam int          TW   = $clog2(TOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    FILL = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   addr_nx;
  logic            req_nx, err_nx, done_nx;
  logic [DW-1:0]   buffer, buf_nx, din_nx;
  logic [TW-1:0]   timer, timer_nx;

  logic active, got, tout, rd_in_range, hi_in_range;

  assign active = ioctl_upload && (ioctl_index == INDEX);
  assign busy   = (state != IDLE);
  assign got    = mem_req && mem_ok;
  assign tout   = mem_req && !mem_ok && (timer == TMAX);

  // The range check uses the full HPS address so that an address beyond the
  // memory is answered with FF instead of aliasing onto a low byte.
  assign rd_in_range = ({5'd0, ioctl_addr} < 32'(SIZE));
  // A fetch in LO only happens for an in-range address, so the upper address
  // bits were zero and mem_addr+1 computed without wrapping is exact here.
  assign hi_in_range = ({{(32-AW){1'b0}}, mem_addr} + 32'd1 < 32'(SIZE));

  always_comb begin
    state_nx = state;
    addr_nx  = mem_addr;
    req_nx   = mem_req;
    buf_nx   = buffer;
    din_nx   = ioctl_din;
    timer_nx = timer;
    err_nx   = (active && !mem_sel) ? 1'b0 : err;
    done_nx  = mem_sel && !active;
    if (!active) begin
      state_nx = IDLE;
      req_nx   = 1'b0;
      timer_nx = '0;
    end else if (ioctl_rd) begin
      // A read arriving mid-fetch abandons the old one and starts afresh.
      if (state != IDLE) err_nx = 1'b1;
      addr_nx  = ioctl_addr[AW-1:0];
      buf_nx   = '1;
      timer_nx = '0;
      if (rd_in_range) begin
        req_nx   = 1'b1;
        state_nx = LO;
      end else begin
        req_nx   = 1'b0;
        state_nx = FILL;
      end
    end else begin
      case (state)
        IDLE: begin end
        LO: begin
          if (got || tout) begin
            if (got) buf_nx[7:0] = mem_dout;
            else     err_nx      = 1'b1;
            req_nx   = 1'b0;
            timer_nx = '0;
            state_nx = FILL;
            if (WIDE != 0) begin
              addr_nx = mem_addr + AW'(1);
              if (hi_in_range) state_nx = HI;
            end
          end else if (mem_req) begin
            timer_nx = timer + TW'(1);
          end
        end
        HI: begin
          // First HI cycle keeps mem_req low so the memory sees a clean edge.
          if (!mem_req) begin
            req_nx = 1'b1;
          end else if (got || tout) begin
            if (got) buf_nx[DW-1 -: 8] = mem_dout;
            else     err_nx            = 1'b1;
            req_nx   = 1'b0;
            timer_nx = '0;
            state_nx = FILL;
          end else begin
            timer_nx = timer + TW'(1);
          end
        end
        FILL: begin
          din_nx   = buffer;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_req   <= 1'b0;
      buffer    <= '1;
      ioctl_din <= '0;
      timer     <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
      mem_sel   <= 1'b0;
    end else begin
      state     <= state_nx;
      mem_addr  <= addr_nx;
      mem_req   <= req_nx;
      buffer    <= buf_nx;
      ioctl_din <= din_nx;
      timer     <= timer_nx;
      err       <= err_nx;
      done      <= done_nx;
      mem_sel   <= active;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtframe_mr_upload.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_jtframe_mr_upload                                                       |
// | Bench for jtframe_mr_upload: an 8-bit and a 16-bit instance share the HPS  |
// | side and each has its own save-memory responder over one memory image.     |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_jtframe_mr_upload;

  logic        clk_rom = 1'b0;
  logic        rst     = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index  = 8'd0;
  logic        ioctl_rd     = 1'b0;
  logic [26:0] ioctl_addr   = 27'd0;

  logic [7:0]  din0;
  logic [15:0] din1;
  logic        sel0, sel1, req0, req1, busy0, busy1, done0, done1, err0, err1;
  logic [9:0]  maddr0, maddr1;
  logic        ok0 = 1'b0, ok1 = 1'b0;
  logic [7:0]  mdout0 = 8'd0, mdout1 = 8'd0;

  logic [7:0]  mem [0:1023];
  int          lat = 3;
  logic        en  = 1'b1;
  int          cnt0 = 0, cnt1 = 0;
  int          rises0 = 0, rises1 = 0, dones0 = 0;
  logic        req0_d = 1'b0, req1_d = 1'b0;
  int          n_chk = 0, n_pass = 0;

  jtframe_mr_upload #(.WIDE(0), .AW(10), .SIZE(1024), .INDEX(8'd2), .TOUT(64)) u0 (
    .clk_rom(clk_rom), .rst(rst), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din0), .mem_sel(sel0),
    .mem_addr(maddr0), .mem_req(req0), .mem_dout(mdout0), .mem_ok(ok0),
    .busy(busy0), .done(done0), .err(err0));

  jtframe_mr_upload #(.WIDE(1), .AW(10), .SIZE(1024), .INDEX(8'd2), .TOUT(64)) u1 (
    .clk_rom(clk_rom), .rst(rst), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din1), .mem_sel(sel1),
    .mem_addr(maddr1), .mem_req(req1), .mem_dout(mdout1), .mem_ok(ok1),
    .busy(busy1), .done(done1), .err(err1));

  always #5 clk_rom = ~clk_rom;

  // Memory responders: mem_ok arrives in the (lat-1)th cycle of a held request.
  always_ff @(posedge clk_rom) begin
    if (!req0 || ok0) begin
      cnt0 <= 0;
      ok0  <= 1'b0;
    end else begin
      cnt0 <= cnt0 + 1;
      if (en && (cnt0 + 1 == lat - 1)) begin
        ok0    <= 1'b1;
        mdout0 <= mem[maddr0];
      end
    end
  end

  always_ff @(posedge clk_rom) begin
    if (!req1 || ok1) begin
      cnt1 <= 0;
      ok1  <= 1'b0;
    end else begin
      cnt1 <= cnt1 + 1;
      if (en && (cnt1 + 1 == lat - 1)) begin
        ok1    <= 1'b1;
        mdout1 <= mem[maddr1];
      end
    end
  end

  always_ff @(posedge clk_rom) begin
    req0_d <= req0;
    req1_d <= req1;
    if (req0 && !req0_d) rises0 <= rises0 + 1;
    if (req1 && !req1_d) rises1 <= rises1 + 1;
    if (done0) dones0 <= dones0 + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_rom);
  endtask

  task automatic rd_pulse(input logic [26:0] a);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    step(1);
    ioctl_rd   = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while ((busy0 || busy1) && k < 400) begin
      step(1);
      k++;
    end
    chk(nm, {31'd0, busy0 | busy1}, 32'd0);
  endtask

  typedef struct {
    logic [26:0] a;
    int          l;
    logic [7:0]  d0;
    logic [15:0] d1;
    int          nr0;
    int          nr1;
  } vec_t;

  vec_t tv [6];

  initial begin
    int r0, r1, dd;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h010] = 8'hA5; mem[10'h011] = 8'h5A;
    mem[10'h020] = 8'h34; mem[10'h021] = 8'h12;
    mem[10'h030] = 8'h3C; mem[10'h031] = 8'hC3;
    mem[10'h100] = 8'h77; mem[10'h101] = 8'h88;
    mem[10'h3FF] = 8'hC3;

    tv[0] = '{27'h010, 3, 8'hA5, 16'h5AA5, 1, 2};
    tv[1] = '{27'h020, 2, 8'h34, 16'h1234, 1, 2};
    tv[2] = '{27'h3FF, 4, 8'hC3, 16'hFFC3, 1, 1};
    tv[3] = '{27'h400, 2, 8'hFF, 16'hFFFF, 0, 0};
    tv[4] = '{27'h100, 6, 8'h77, 16'h8877, 1, 2};
    tv[5] = '{27'h7F0, 2, 8'hFF, 16'hFFFF, 0, 0};

    // Reset state
    #2 rst = 1'b1;
    step(2);
    chk("rst_din0", {24'd0, din0}, 32'd0);
    chk("rst_din1", {16'd0, din1}, 32'd0);
    chk("rst_sel", {30'd0, sel0, sel1}, 32'd0);
    chk("rst_addr", {12'd0, maddr0, maddr1}, 32'd0);
    chk("rst_ctl", {26'd0, req0, req1, busy0, busy1, err0 | done0, err1 | done1}, 32'd0);
    rst = 1'b0;

    ioctl_upload = 1'b1;
    ioctl_index  = 8'd2;
    step(2);
    chk("sel_on", {30'd0, sel0, sel1}, 32'd3);

    // Cycle-exact latency, L=3
    lat = 3; en = 1'b1;
    rd_pulse(27'h010);                                   // now at rd+1
    chk("req0_rd1", {31'd0, req0}, 32'd1);
    chk("addr0_rd1", {22'd0, maddr0}, 32'h010);
    chk("busy0_rd1", {31'd0, busy0}, 32'd1);
    step(3);                                             // rd+4
    chk("req1_gap", {31'd0, req1}, 32'd0);
    chk("addr1_hi", {22'd0, maddr1}, 32'h011);
    step(1);                                             // rd+5
    chk("din0_lat", {24'd0, din0}, 32'hA5);
    chk("busy0_after", {31'd0, busy0}, 32'd0);
    chk("req1_hi", {31'd0, req1}, 32'd1);
    step(3);                                             // rd+8
    chk("din1_early", {16'd0, din1}, 32'd0);
    step(1);                                             // rd+9
    chk("din1_lat", {16'd0, din1}, 32'h5AA5);

    // Table of single reads
    for (int i = 0; i < 6; i++) begin
      lat = tv[i].l;
      r0 = rises0; r1 = rises1;
      rd_pulse(tv[i].a);
      wait_idle($sformatf("v%0d_tmo", i));
      step(1);
      chk($sformatf("v%0d_din0", i), {24'd0, din0}, {24'd0, tv[i].d0});
      chk($sformatf("v%0d_din1", i), {16'd0, din1}, {16'd0, tv[i].d1});
      chk($sformatf("v%0d_err", i), {30'd0, err0, err1}, 32'd0);
      chk($sformatf("v%0d_nreq0", i), rises0 - r0, tv[i].nr0);
      chk($sformatf("v%0d_nreq1", i), rises1 - r1, tv[i].nr1);
    end

    // Timeout: memory never answers
    en = 1'b0;
    rd_pulse(27'h010);                                   // rd+1
    step(63);                                            // rd+64
    chk("tout_req_held", {31'd0, req0}, 32'd1);
    step(1);                                             // rd+65
    chk("tout_req_drop", {31'd0, req0}, 32'd0);
    chk("tout_err0", {31'd0, err0}, 32'd1);
    step(1);                                             // rd+66
    chk("tout_din0", {24'd0, din0}, 32'hFF);
    wait_idle("tout_w1");
    chk("tout_din1", {16'd0, din1}, 32'hFFFF);
    chk("tout_err1", {31'd0, err1}, 32'd1);
    en = 1'b1;

    // Session end: done pulse, err cleared on next session
    ioctl_upload = 1'b0;
    chk("done_before", {30'd0, done0, done1}, 32'd0);
    step(1);
    chk("done_pulse", {30'd0, done0, done1}, 32'd3);
    chk("sel_off", {30'd0, sel0, sel1}, 32'd0);
    step(1);
    chk("done_end", {30'd0, done0, done1}, 32'd0);
    ioctl_upload = 1'b1;
    step(1);
    chk("err_clear", {30'd0, err0, err1}, 32'd0);

    // Overrun: second read while the first is in LO
    lat = 3;
    rd_pulse(27'h010);
    rd_pulse(27'h030);
    wait_idle("ovr_tmo");
    step(1);
    chk("ovr_err", {30'd0, err0, err1}, 32'd3);
    chk("ovr_din0", {24'd0, din0}, 32'h3C);
    chk("ovr_din1", {16'd0, din1}, 32'hC33C);
    ioctl_upload = 1'b0;
    step(2);
    ioctl_upload = 1'b1;
    step(2);
    chk("ovr_clear", {30'd0, err0, err1}, 32'd0);

    // Wrong index: reads ignored
    ioctl_upload = 1'b0;
    ioctl_index  = 8'd0;
    step(3);
    ioctl_upload = 1'b1;
    step(2);
    chk("idx_sel", {30'd0, sel0, sel1}, 32'd0);
    r0 = rises0; r1 = rises1; dd = dones0;
    rd_pulse(27'h010);
    step(10);
    rd_pulse(27'h020);
    step(10);
    chk("idx_noreq", (rises0 - r0) + (rises1 - r1), 32'd0);
    chk("idx_din0", {24'd0, din0}, 32'h3C);
    chk("idx_din1", {16'd0, din1}, 32'hC33C);
    ioctl_upload = 1'b0;
    step(3);
    chk("idx_nodone", dones0 - dd, 32'd0);

    // Asynchronous reset in the middle of a fetch
    ioctl_upload = 1'b1;
    ioctl_index  = 8'd2;
    step(2);
    lat = 8;
    rd_pulse(27'h100);
    step(1);
    chk("mid_req", {30'd0, req0, req1}, 32'd3);
    #1 rst = 1'b1;
    #1;
    chk("mid_din", {din1, din0}, 32'd0);
    chk("mid_addr", {12'd0, maddr0, maddr1}, 32'd0);
    chk("mid_ctl", {22'd0, sel0, sel1, req0, req1, busy0, busy1, done0, done1, err0, err1},
        32'd0);
    step(2);
    rst = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
